// File: rtl/cr_ahbl_pkg.sv
// Shared AHB-Lite encodings and controller state type for the cr_ahbl master controller.
package cr_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DPH  = 2'b01,
        ST_ERR  = 2'b10
    } ahbl_state_e;

endpackage

// File: rtl/cr_ahbl_master_ctrl.sv
// AHB-Lite master protocol controller: turns the arbiter's merged request into
// pipelined address/data phases with one outstanding data phase and ERROR handling.
module cr_ahbl_master_ctrl
    import cr_ahbl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              ahbl_gated_clk,
    input  logic              cpurst,
    input  logic              cpu_req,
    input  logic              cpu_req_for_grnt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_prot,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_req_grnt,
    output logic              cpu_trans_cmplt,
    output logic              cpu_data_vld,
    output logic              cpu_acc_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_sec,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    ahbl_state_e state_q, state_d;
    logic        dph_write_q, dph_write_d;
    logic        dph_vld_q, dph_vld_d;
    logic        err_resp;
    logic        issue;
    logic        grant;

    assign err_resp = (hresp == HRESP_ERROR);

    // Reset also masks the address phase so every output reads zero while cpurst is held.
    assign issue = !cpurst && cpu_req && cpu_req_for_grnt && (state_q != ST_ERR)
                   && !((state_q == ST_DPH) && err_resp);
    assign grant = issue && hready;

    always_ff @(posedge ahbl_gated_clk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= ST_IDLE;
            dph_write_q <= 1'b0;
            dph_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dph_write_q <= dph_write_d;
            dph_vld_q   <= dph_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dph_write_d = dph_write_q;
        dph_vld_d   = dph_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_DPH;
            end
            ST_DPH: begin
                if (err_resp) begin
                    state_d = hready ? ST_IDLE : ST_ERR;
                end else if (hready) begin
                    state_d = grant ? ST_DPH : ST_IDLE;
                end
            end
            ST_ERR: begin
                if (hready && err_resp) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            dph_write_d = cpu_write;
            dph_vld_d   = 1'b1;
        end else if (cpu_trans_cmplt) begin
            dph_vld_d   = 1'b0;
        end
    end

    always_comb begin
        htrans          = HTRANS_IDLE;
        haddr           = '0;
        hsize           = '0;
        hprot           = '0;
        hwrite          = 1'b0;
        hwdata          = '0;
        cpu_trans_cmplt = 1'b0;
        cpu_acc_err     = 1'b0;
        cpu_data_vld    = 1'b0;
        if (issue) begin
            htrans = HTRANS_NONSEQ;
            haddr  = cpu_addr;
            hsize  = {1'b0, cpu_size};
            hprot  = cpu_prot;
            hwrite = cpu_write;
        end
        case (state_q)
            ST_DPH: begin
                if (dph_vld_q && dph_write_q) hwdata = cpu_wdata;
                if (hready) begin
                    cpu_trans_cmplt = 1'b1;
                    cpu_acc_err     = err_resp;
                    cpu_data_vld    = !err_resp && !dph_write_q;
                end
            end
            ST_ERR: begin
                if (hready && err_resp) begin
                    cpu_trans_cmplt = 1'b1;
                    cpu_acc_err     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cpu_req_grnt = grant;
    assign cpu_rdata    = cpu_data_vld ? hrdata : '0;
    assign hburst       = HBURST_SINGLE;
    assign cpu_sec      = 1'b0;

endmodule

// File: doc/cr_ahbl_master_ctrl.md
Name: cr_ahbl_master_ctrl

Overview:
AHB-Lite master-side protocol controller sitting directly downstream of the ibus/dbus request arbiter. It converts the arbiter's single merged request (cpu_req/cpu_addr/...) into AHB-Lite address and data phases and returns cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err and cpu_rdata to the arbiter. It tracks at most one outstanding data phase and handles wait states and the two-cycle ERROR response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
ahbl_gated_clk  in  1  clock
cpurst  in  1  reset, asynchronous, active-high
cpu_req  in  1  merged request from arbiter
cpu_req_for_grnt  in  1  request qualifier; grant only considered when set
cpu_addr  in  ADDR_W  request address
cpu_prot  in  4  HPROT value
cpu_size  in  2  00 byte, 01 half, 10 word
cpu_write  in  1  1 = write
cpu_wdata  in  DATA_W  write data, data-phase aligned by arbiter
cpu_req_grnt  out  1  address phase accepted this cycle
cpu_trans_cmplt  out  1  data phase finished (OKAY or ERROR)
cpu_data_vld  out  1  read data valid on cpu_rdata
cpu_acc_err  out  1  transfer ended with ERROR
cpu_rdata  out  DATA_W  read data
cpu_sec  out  1  tied 0 (no secure attribute)
htrans  out  2  00 IDLE / 10 NONSEQ
haddr  out  ADDR_W  address
hsize  out  3  {1'b0, cpu_size}
hburst  out  3  fixed 000 (SINGLE)
hprot  out  4  protection
hwrite  out  1  direction
hwdata  out  DATA_W  write data
hready  in  1  AHB HREADY
hresp  in  1  AHB HRESP (0 OKAY, 1 ERROR)
hrdata  in  DATA_W  AHB read data

Behaviour:
- FSM states: IDLE (no data phase), DPH (data phase outstanding), ERR (first ERROR cycle seen, waiting second). Reset → IDLE.
- Address phase is combinational: issue = cpu_req && cpu_req_for_grnt && state!=ERR && !(state==DPH && hresp).
- htrans = issue ? NONSEQ : IDLE. haddr/hsize/hprot/hwrite follow cpu_* when issue is 1, and are 0 otherwise.
- cpu_req_grnt = issue && hready.
- Upstream guarantees cpu_* are stable while cpu_req && !cpu_req_grnt. This block does not latch address-phase control.
- Data-phase registers dph_write and dph_vld load on cpu_req_grnt. hwdata = cpu_wdata while in DPH with dph_write set, else 0.
- IDLE: on grant → DPH; else stay.
- DPH, hready && !hresp: cpu_trans_cmplt=1; cpu_data_vld = !dph_write; cpu_rdata = hrdata. Next state is DPH if a new grant occurs in the same cycle (back-to-back pipelining), else IDLE.
- DPH, !hready && !hresp: wait; outputs 0; stay.
- DPH, !hready && hresp: → ERR. htrans forced IDLE from the next cycle; any NONSEQ driven this cycle is not granted.
- ERR, hready && hresp: cpu_trans_cmplt=1, cpu_acc_err=1, cpu_data_vld=0 → IDLE. No grant in this cycle.
- ERR, otherwise: stay.
- DPH, hready && hresp (single-cycle error, slave violation): treat as an ERROR completion → IDLE; no grant that cycle.
- cpu_rdata = hrdata when cpu_data_vld, else 0.
- Reset values: all outputs 0, htrans IDLE, hburst 000.
- Reset mid-transfer: state → IDLE immediately; the outstanding data phase is abandoned with no cmplt pulse.
- At most one cmplt pulse per granted transfer. cpu_trans_cmplt and cpu_req_grnt may coincide.

Decomposition:
- Shared package cr_ahbl_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HBURST_SINGLE=3'b000
  - HRESP_OKAY/HRESP_ERROR
  - FSM state encodings IDLE/DPH/ERR (2 bits)
- No sub-module; single flat module.

Test Plan:
- Single read at 0x0000_1000, slave hready=1, hrdata=0xDEADBEEF:
  - cycle0: htrans=10, grnt=1.
  - cycle1: cmplt=1, data_vld=1, cpu_rdata=0xDEADBEEF.
- Write 0x2000_0004, size=10, wdata=0x12345678, slave inserts 2 wait states:
  - cycle0: grnt=1.
  - cycles 1–3: hwdata=0x12345678.
  - cmplt=1 in cycle3; data_vld=0.
- Back-to-back reads to 0x100 and 0x104 with hready=1: grnt in cycles 0 and 1; cmplt in cycles 1 and 2; state stays DPH through cycle1.
- ERROR response while a new request 0x200 is pending:
  - cycle1: hresp=1, hready=0.
  - cycle2: hresp=1, hready=1 → htrans=00 and no grnt in cycle2; cmplt=1 and acc_err=1 in cycle2.
  - 0x200 is granted in cycle3.
- Request with cpu_req_for_grnt=0 → htrans=00, grnt=0; state remains IDLE.
- Assert cpurst while in DPH with hready=0 → all outputs 0 that cycle, no cmplt after release, state IDLE.
